multicycle_sequencer: RTL and testbench

Controls the multicycle path of the i281 multicycle core. It watches each fetched instruction, owns the `multicycle_flag` that steers `curr_instruction[7:0]` to either the opcode decoder or the multicycle opcode decoder, and stalls fetch while it steps a latched multicycle instruction through its micro-steps. It sits between fetch/PC logic and the multicycle decoder, producing the flag the decoder consumes.

---
 rtl/mc_pkg.sv | 15 +
 rtl/multicycle_sequencer_if.sv | 35 +++
 rtl/multicycle_sequencer.sv | 106 ++++++++++
 tb/tb_multicycle_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and field positions for the i281 multicycle sequencer.
// The instruction layout is fixed at 9 bits: class bit above an 8-bit opcode payload.
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    localparam int MC_CLASS_BIT = 8;
    localparam int MC_STEPS_MSB = 7;
    localparam int MC_STEPS_LSB = 5;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Fetch-to-sequencer bundle: fetch (master) presents instructions, the sequencer (slave)
// returns the decoder flag, held opcode, stall and step. mc_abort exists only with MC_ABORT_EN.
interface multicycle_sequencer_if #(
    parameter int STEP_W = 3
);
    logic              instr_valid;
    logic [8:0]        curr_instruction;
`ifdef MC_ABORT_EN
    logic              mc_abort;
`endif
    logic              multicycle_flag;
    logic [7:0]        held_instruction;
    logic              pc_stall;
    logic [STEP_W-1:0] step;
    logic              step_valid;
    logic              mc_done;
    logic              mc_busy;

    modport master (
`ifdef MC_ABORT_EN
        output mc_abort,
`endif
        output instr_valid, curr_instruction,
        input  multicycle_flag, held_instruction, pc_stall, step, step_valid, mc_done, mc_busy
    );

    modport slave (
`ifdef MC_ABORT_EN
        input  mc_abort,
`endif
        input  instr_valid, curr_instruction,
        output multicycle_flag, held_instruction, pc_stall, step, step_valid, mc_done, mc_busy
    );

endinterface

// File: rtl/multicycle_sequencer.sv
// Latches a multicycle instruction, stalls fetch and walks it through its micro-steps.
// Define MC_ABORT_EN to add the mc_abort flush input.
module multicycle_sequencer
    import mc_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    multicycle_sequencer_if.slave        bus
);

    mc_state_t         state;
    mc_state_t         state_next;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] last_step_q;
    logic [7:0]        held_q;
    logic              abort;
    logic              accept;
    logic              at_last;

    logic              flag_c;
    logic              stall_c;
    logic              step_valid_c;
    logic              done_c;
    logic              busy_c;

`ifdef MC_ABORT_EN
    assign abort = bus.mc_abort;
`else
    assign abort = 1'b0;
`endif

    // rst_n is folded in so the Mealy stall is also forced low while reset is held.
    assign accept  = rst_n && (state == IDLE) && bus.instr_valid
                     && bus.curr_instruction[MC_CLASS_BIT] && !abort;
    assign at_last = (step_q == last_step_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every comb output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (at_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_comb begin
        flag_c       = 1'b0;
        stall_c      = 1'b0;
        step_valid_c = 1'b0;
        done_c       = 1'b0;
        busy_c       = 1'b0;
        case (state)
            IDLE: stall_c = accept;
            RUN: begin
                flag_c       = 1'b1;
                stall_c      = 1'b1;
                step_valid_c = 1'b1;
                busy_c       = 1'b1;
            end
            DONE: begin
                flag_c = 1'b1;
                done_c = 1'b1;
                busy_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Step stops at last_step, so an 8-step sequence at STEP_W=3 never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            last_step_q <= '0;
            held_q      <= '0;
        end else if (accept) begin
            held_q      <= bus.curr_instruction[7:0];
            last_step_q <= STEP_W'(bus.curr_instruction[MC_STEPS_MSB:MC_STEPS_LSB]);
            step_q      <= '0;
        end else if ((state == RUN) && !at_last && !abort) begin
            step_q <= step_q + STEP_W'(1);
        end
    end

    assign bus.multicycle_flag  = flag_c;
    assign bus.pc_stall         = stall_c;
    assign bus.step_valid       = step_valid_c;
    assign bus.mc_done          = done_c;
    assign bus.mc_busy          = busy_c;
    assign bus.step             = step_q;
    assign bus.held_instruction = held_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed and random instruction streams against a
// schedule-queue model; abort scenarios are exercised when MC_ABORT_EN is defined.
module tb_multicycle_sequencer;

    localparam int STEP_W = 3;

    typedef struct packed {
        logic              flag;
        logic              stall;
        logic [STEP_W-1:0] step;
        logic              step_valid;
        logic              done;
        logic              busy;
        logic [7:0]        held;
    } obs_t;

    // One entry per future cycle of an accepted instruction.
    typedef struct {
        bit is_done;
        int step;
    } slot_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       valid_in = 1'b0;
    logic       abort_in = 1'b0;
    logic [8:0] instr_in = '0;

    always #5 clk = ~clk;

    multicycle_sequencer_if #(.STEP_W(STEP_W)) bus ();
    assign bus.instr_valid      = valid_in;
    assign bus.curr_instruction = instr_in;
`ifdef MC_ABORT_EN
    assign bus.mc_abort         = abort_in;
`endif

    multicycle_sequencer #(.STEP_W(STEP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    slot_t      sched[$];
    int         idle_step;
    logic [7:0] m_held;
    int         vectors     = 0;
    int         miscompares = 0;
    obs_t       e;
    obs_t       o;

    task automatic model_reset();
        sched.delete();
        idle_step = 0;
        m_held    = '0;
    endtask

    function automatic obs_t expected();
        obs_t r;
        r = '0;
        if (!rst_n) return r;
        r.held = m_held;
        if (sched.size() == 0) begin
            r.step  = STEP_W'(idle_step);
            r.stall = valid_in & instr_in[8] & ~abort_in;
        end else begin
            r.flag = 1'b1;
            r.busy = 1'b1;
            r.step = STEP_W'(sched[0].step);
            if (sched[0].is_done) begin
                r.done = 1'b1;
            end else begin
                r.stall      = 1'b1;
                r.step_valid = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic obs_t observed();
        return {bus.multicycle_flag, bus.pc_stall, bus.step, bus.step_valid,
                bus.mc_done, bus.mc_busy, bus.held_instruction};
    endfunction

    // Clock edge: update the model from the inputs seen at the edge, then re-drive after it.
    task automatic advance();
        int n;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (abort_in) begin
            if (sched.size() != 0) idle_step = sched[0].step;
            sched.delete();
        end else if (sched.size() == 0) begin
            if (valid_in && instr_in[8]) begin
                m_held = instr_in[7:0];
                n = int'(instr_in[7:5]) + 1;
                for (int i = 0; i < n; i++) sched.push_back('{is_done: 1'b0, step: i});
                sched.push_back('{is_done: 1'b1, step: n - 1});
            end
        end else begin
            idle_step = sched[0].step;
            void'(sched.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        rst_n    = 1'b0;
        valid_in = 1'b1;
        instr_in = 9'h1E0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %h expected %h", i, o, e);
            end
            advance();
        end
        valid_in = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_single_cycle();
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            instr_in = (i == 0) ? 9'h042 : {1'b0, 8'($urandom)};
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL single_cycle[%0d] instr=%h: got %h expected %h", i, instr_in, o, e);
            end
            advance();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_three_step();
        for (int i = 0; i < 7; i++) begin
            valid_in = (i == 0);
            instr_in = 9'h14A;
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL three_step[T+%0d]: got %h expected %h", i, o, e);
            end
            advance();
        end
    endtask

    task automatic test_eight_step();
        for (int i = 0; i < 11; i++) begin
            // Multicycle instructions offered mid-sequence must be ignored.
            valid_in = (i == 0) ? 1'b1 : (i < 10) ? 1'($urandom) : 1'b0;
            instr_in = (i == 0) ? 9'h1FF : {1'b1, 8'($urandom)};
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL eight_step[T+%0d]: got %h expected %h", i, o, e);
            end
            advance();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            valid_in = 1'b1;
            instr_in = {1'b1, 8'($urandom)};
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, o, e);
            end
            advance();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_mid_run_reset();
        // Let any sequence left over from earlier tests drain first.
        for (int i = 0; i < 12; i++) advance();
        for (int i = 0; i < 3; i++) begin
            valid_in = (i == 0);
            instr_in = 9'h1E0;
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mid_reset_run[T+%0d]: got %h expected %h", i, o, e);
            end
            advance();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        e = expected(); o = observed(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mid_reset_async: got %h expected %h", o, e);
        end
        @(negedge clk);
        e = expected(); o = observed(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mid_reset_held: got %h expected %h", o, e);
        end
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            valid_in = (i == 0);
            instr_in = 9'h1A3;
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mid_reset_recover[T+%0d]: got %h expected %h", i, o, e);
            end
            advance();
        end
        valid_in = 1'b0;
    endtask

`ifdef MC_ABORT_EN
    task automatic test_abort();
        for (int i = 0; i < 12; i++) advance();
        for (int i = 0; i < 8; i++) begin
            valid_in = (i == 0) || (i == 2) || (i == 6);
            instr_in = (i == 6) ? 9'h121 : 9'h1E0;
            abort_in = (i == 2) || (i == 6);
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL abort[T+%0d]: got %h expected %h", i, o, e);
            end
            advance();
        end
        valid_in = 1'b0;
        abort_in = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid_in = 1'($urandom);
            instr_in = 9'($urandom);
`ifdef MC_ABORT_EN
            abort_in = ($urandom_range(0, 15) == 0);
`endif
            @(negedge clk);
            e = expected(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL random[%0d] v=%b instr=%h ab=%b: got %h expected %h",
                         i, valid_in, instr_in, abort_in, o, e);
            end
            advance();
        end
        valid_in = 1'b0;
        abort_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_three_step();
        test_eight_step();
        test_back_to_back();
        test_mid_run_reset();
`ifdef MC_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
